// File: rtl/rng_ctrl_pkg.sv
// Shared types and default sizes for the random-roll controller.
package rng_ctrl_pkg;

    // Controller sequencing states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_ROLL = 2'd2
    } state_t;

    localparam int DEPTH_DEF       = 16;
    localparam int VAL_W_DEF       = 4;
    localparam int ARM_TIMEOUT_DEF = 1024;
    localparam int IDX_W           = $clog2(DEPTH_DEF);

endpackage

// File: rtl/rng_hist_buf.sv
// Circular roll history: one write port that appends at wr_ptr, and a
// combinational read port addressed by offset from the newest entry.
module rng_hist_buf
    import rng_ctrl_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int VAL_W = VAL_W_DEF
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     wr_en,
    input  logic [VAL_W-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_ofs,
    output logic [VAL_W-1:0]         rd_data,
    output logic [$clog2(DEPTH)-1:0] wr_ptr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    logic [VAL_W-1:0] mem_r [DEPTH];
    logic [IW-1:0]    wr_ptr_r;
    logic [CW-1:0]    count_r;
    logic [IW-1:0]    rd_addr_s;

    // Storage array; contents are never read while count is zero, so no reset
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Write pointer wraps naturally (DEPTH is a power of two); count saturates
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else if (wr_en) begin
            wr_ptr_r <= wr_ptr_r + IW'(1);
            if (count_r != CW'(DEPTH)) begin
                count_r <= count_r + CW'(1);
            end else begin
                count_r <= count_r;
            end
        end else begin
            wr_ptr_r <= wr_ptr_r;
            count_r  <= count_r;
        end
    end

    // Offset 0 addresses the most recently written entry
    always_comb begin
        rd_addr_s = wr_ptr_r - IW'(1) - rd_ofs;
        rd_data   = mem_r[rd_addr_s];
    end

    assign wr_ptr = wr_ptr_r;
    assign count  = count_r;

endmodule

// File: rtl/rng_roll_ctrl.sv
// Roll controller: turns key pulses into generator start/stop pulses,
// records finished rolls and selects live or browsed value for display.
module rng_roll_ctrl
    import rng_ctrl_pkg::*;
#(
    parameter int DEPTH       = DEPTH_DEF,
    parameter int ARM_TIMEOUT = ARM_TIMEOUT_DEF,
    parameter int VAL_W       = VAL_W_DEF
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic                     i_prev,
    input  logic                     i_next,
    input  logic [VAL_W-1:0]         i_rng_value,
    input  logic                     i_rng_busy,
    output logic                     o_rng_start,
    output logic [VAL_W-1:0]         o_display,
    output logic [$clog2(DEPTH)-1:0] o_index,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_rolling,
    output logic                     o_error
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam int TW = $clog2(ARM_TIMEOUT + 1);

    state_t           state_r, state_nxt_s;
    logic [IW-1:0]    idx_r, idx_nxt_s;
    logic [TW-1:0]    tmo_r, tmo_nxt_s;
    logic             busy_d_r;
    logic             start_r, start_nxt_s;
    logic             err_r, err_nxt_s;
    logic             rolling_r;
    logic [VAL_W-1:0] disp_r, disp_nxt_s;

    logic             wr_en_s;
    logic [VAL_W-1:0] rd_data_s;
    logic [IW-1:0]    wr_ptr_unused_s;
    logic [CW-1:0]    count_s;

    rng_hist_buf #(
        .DEPTH (DEPTH),
        .VAL_W (VAL_W)
    ) u_hist (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .wr_en   (wr_en_s),
        .wr_data (i_rng_value),
        .rd_ofs  (idx_nxt_s),
        .rd_data (rd_data_s),
        .wr_ptr  (wr_ptr_unused_s),
        .count   (count_s)
    );

    // State, browse index, timeout counter and all output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r   <= S_IDLE;
            idx_r     <= '0;
            tmo_r     <= '0;
            busy_d_r  <= 1'b0;
            start_r   <= 1'b0;
            err_r     <= 1'b0;
            rolling_r <= 1'b0;
            disp_r    <= '0;
        end else begin
            state_r   <= state_nxt_s;
            idx_r     <= idx_nxt_s;
            tmo_r     <= tmo_nxt_s;
            busy_d_r  <= i_rng_busy;
            start_r   <= start_nxt_s;
            err_r     <= err_nxt_s;
            rolling_r <= (state_nxt_s != S_IDLE);
            disp_r    <= disp_nxt_s;
        end
    end

    // Next-state, browse and display selection
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        tmo_nxt_s   = tmo_r;
        start_nxt_s = 1'b0;
        err_nxt_s   = err_r;
        disp_nxt_s  = disp_r;
        wr_en_s     = 1'b0;

        case (state_r)
            S_IDLE: begin
                if (i_start) begin
                    // Start beats any browse key arriving in the same cycle
                    start_nxt_s = 1'b1;
                    err_nxt_s   = 1'b0;
                    tmo_nxt_s   = '0;
                    state_nxt_s = S_ARM;
                end else if (i_prev && !i_next) begin
                    if ((CW'(idx_r) + CW'(1)) < count_s) begin
                        idx_nxt_s = idx_r + IW'(1);
                    end else begin
                        idx_nxt_s = idx_r;
                    end
                end else if (i_next && !i_prev) begin
                    if (idx_r != IW'(0)) begin
                        idx_nxt_s = idx_r - IW'(1);
                    end else begin
                        idx_nxt_s = idx_r;
                    end
                end else begin
                    idx_nxt_s = idx_r;
                end
                // Read port uses the next index so display and index move together
                if (count_s == CW'(0)) begin
                    disp_nxt_s = '0;
                end else begin
                    disp_nxt_s = rd_data_s;
                end
            end

            S_ARM: begin
                if (i_rng_busy) begin
                    state_nxt_s = S_ROLL;
                end else if (tmo_r == TW'(ARM_TIMEOUT - 1)) begin
                    err_nxt_s   = 1'b1;
                    state_nxt_s = S_IDLE;
                end else begin
                    tmo_nxt_s = tmo_r + TW'(1);
                end
            end

            S_ROLL: begin
                disp_nxt_s = i_rng_value;
                if (busy_d_r && !i_rng_busy) begin
                    // Roll finished: the value present now is the result
                    wr_en_s     = 1'b1;
                    idx_nxt_s   = '0;
                    state_nxt_s = S_IDLE;
                end else if (i_start && !start_r) begin
                    // Stop request; never pulse on back-to-back cycles
                    start_nxt_s = 1'b1;
                end else begin
                    start_nxt_s = 1'b0;
                end
            end

            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    assign o_rng_start = start_r;
    assign o_display   = disp_r;
    assign o_index     = idx_r;
    assign o_count     = count_s;
    assign o_rolling   = rolling_r;
    assign o_error     = err_r;

endmodule

// File: tb/tb_rng_roll_ctrl.sv
// Directed bench for rng_roll_ctrl with a simple generator model.
module tb_rng_roll_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic       i_prev = 1'b0;
    logic       i_next = 1'b0;
    logic [3:0] i_rng_value = 4'h0;
    logic       i_rng_busy = 1'b0;
    logic       o_rng_start;
    logic [3:0] o_display;
    logic [3:0] o_index;
    logic [4:0] o_count;
    logic       o_rolling;
    logic       o_error;

    int tests = 0;
    int fails = 0;

    rng_roll_ctrl #(
        .DEPTH       (16),
        .ARM_TIMEOUT (1024),
        .VAL_W       (4)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_prev      (i_prev),
        .i_next      (i_next),
        .i_rng_value (i_rng_value),
        .i_rng_busy  (i_rng_busy),
        .o_rng_start (o_rng_start),
        .o_display   (o_display),
        .o_index     (o_index),
        .o_count     (o_count),
        .o_rolling   (o_rolling),
        .o_error     (o_error)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        i_start = 1'b0; i_prev = 1'b0; i_next = 1'b0; i_rng_busy = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
    endtask

    task automatic press_prev();
        @(negedge i_clk); i_prev = 1'b1;
        @(negedge i_clk); i_prev = 1'b0;
    endtask

    task automatic press_next();
        @(negedge i_clk); i_next = 1'b1;
        @(negedge i_clk); i_next = 1'b0;
    endtask

    // One full roll: busy rises 3 cycles after start, stays 20 cycles, ends on v
    task automatic roll(input logic [3:0] v, output int pulses, output int not_rolling);
        pulses = 0;
        not_rolling = 0;
        @(negedge i_clk); i_start = 1'b1;
        @(negedge i_clk); i_start = 1'b0;
        if (o_rng_start) pulses++;
        if (!o_rolling) not_rolling++;
        repeat (2) begin
            @(negedge i_clk);
            if (o_rng_start) pulses++;
            if (!o_rolling) not_rolling++;
        end
        i_rng_busy = 1'b1;
        i_rng_value = ~v;
        repeat (20) begin
            @(negedge i_clk);
            if (o_rng_start) pulses++;
            if (!o_rolling) not_rolling++;
        end
        i_rng_busy = 1'b0;
        i_rng_value = v;
        @(negedge i_clk);
    endtask

    initial begin
        int p, nr, cyc;

        // Reset state
        #2;
        check("rst_start", o_rng_start, 0);
        check("rst_display", o_display, 0);
        check("rst_index", o_index, 0);
        check("rst_count", o_count, 0);
        check("rst_rolling", o_rolling, 0);
        check("rst_error", o_error, 0);
        do_reset();

        // First roll
        roll(4'h9, p, nr);
        check("r1_pulses", p, 1);
        check("r1_rolling_gaps", nr, 0);
        check("r1_rolling_end", o_rolling, 0);
        check("r1_display", o_display, 4'h9);
        check("r1_count", o_count, 1);
        check("r1_index", o_index, 0);

        // Browse over five entries
        do_reset();
        for (int i = 1; i <= 5; i++) roll(4'(i), p, nr);
        check("b_count", o_count, 5);
        check("b_newest", o_display, 4'h5);
        repeat (2) press_prev();
        check("b_prev2_idx", o_index, 2);
        check("b_prev2_disp", o_display, 4'h3);
        repeat (5) press_prev();
        check("b_sat_idx", o_index, 4);
        check("b_sat_disp", o_display, 4'h1);
        repeat (6) press_next();
        check("b_next_idx", o_index, 0);
        check("b_next_disp", o_display, 4'h5);

        // Wrap-around: 17 rolls into a 16-deep buffer
        do_reset();
        for (int i = 0; i < 16; i++) roll(4'(i), p, nr);
        roll(4'hA, p, nr);
        check("w_count", o_count, 16);
        check("w_newest", o_display, 4'hA);
        repeat (15) press_prev();
        check("w_oldest_idx", o_index, 15);
        check("w_oldest_disp", o_display, 4'h1);

        // Arm timeout
        @(negedge i_clk); i_start = 1'b1;
        @(negedge i_clk); i_start = 1'b0;
        check("t_pulse", o_rng_start, 1);
        cyc = 0;
        while (!o_error && cyc < 2000) begin
            @(negedge i_clk);
            cyc++;
        end
        check("t_latency", cyc, 1024);
        check("t_idle", o_rolling, 0);
        check("t_count", o_count, 16);
        repeat (3) @(negedge i_clk);
        check("t_sticky", o_error, 1);
        roll(4'h7, p, nr);
        check("t_cleared", o_error, 0);
        check("t_roll_disp", o_display, 4'h7);

        // Simultaneous prev/next ignored
        repeat (2) press_prev();
        check("pn_idx2", o_index, 2);
        @(negedge i_clk); i_prev = 1'b1; i_next = 1'b1;
        @(negedge i_clk); i_prev = 1'b0; i_next = 1'b0;
        check("pn_both", o_index, 2);

        // Stop pulse and ignored browse during a roll
        @(negedge i_clk); i_start = 1'b1;
        @(negedge i_clk); i_start = 1'b0;
        check("s_pulse", o_rng_start, 1);
        repeat (2) @(negedge i_clk);
        i_rng_busy = 1'b1; i_rng_value = 4'hF;
        repeat (3) @(negedge i_clk);
        check("s_live_disp", o_display, 4'hF);
        @(negedge i_clk); i_start = 1'b1;
        @(negedge i_clk);
        check("s_stop_pulse", o_rng_start, 1);
        @(negedge i_clk); i_start = 1'b0;
        check("s_no_double", o_rng_start, 0);
        check("s_still_roll", o_rolling, 1);
        press_prev();
        check("s_idx_frozen", o_index, 2);
        i_rng_busy = 1'b0; i_rng_value = 4'h3;
        @(negedge i_clk);
        check("s_end_disp", o_display, 4'h3);
        check("s_end_idx", o_index, 0);
        check("s_end_idle", o_rolling, 0);

        // Start and prev together: start wins
        @(negedge i_clk); i_start = 1'b1; i_prev = 1'b1;
        @(negedge i_clk); i_start = 1'b0; i_prev = 1'b0;
        check("sp_pulse", o_rng_start, 1);
        check("sp_rolling", o_rolling, 1);
        check("sp_idx", o_index, 0);

        // Asynchronous reset mid-roll
        repeat (2) @(negedge i_clk);
        i_rng_busy = 1'b1; i_rng_value = 4'h6;
        repeat (3) @(negedge i_clk);
        check("ar_pre_disp", o_display, 4'h6);
        #2 i_rst_n = 1'b0;
        #1;
        check("ar_start", o_rng_start, 0);
        check("ar_display", o_display, 0);
        check("ar_index", o_index, 0);
        check("ar_count", o_count, 0);
        check("ar_rolling", o_rolling, 0);
        check("ar_error", o_error, 0);
        i_rng_busy = 1'b0;
        @(negedge i_clk); i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
        check("ar_post_disp", o_display, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
